// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates instruction fetch and load-store requests onto a byte-wide RAM,
// serialising each access into per-byte cycles and assembling read data little-endian.
module mem_ctrl #(
  parameter int unsigned ADR_W = 32,
  parameter int unsigned DAT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [7:0]       mem_din,
  output logic [7:0]       mem_dout,
  output logic [ADR_W-1:0] mem_a,
  output logic             mem_wr,
  input  logic             io_buffer_full,
  input  logic             if_en_i,
  input  logic [ADR_W-1:0] if_adr_i,
  output logic             if_done_o,
  output logic [DAT_W-1:0] if_dat_o,
  input  logic             lsb_en_i,
  input  logic             lsb_rwen_i,
  input  logic [2:0]       lsb_len_i,
  input  logic [ADR_W-1:0] lsb_adr_i,
  input  logic [DAT_W-1:0] lsb_dat_i,
  output logic             lsb_done_o,
  output logic [DAT_W-1:0] lsb_dat_o,
  input  logic             br_flag_i
);

  localparam int unsigned NB = DAT_W / 8;

  typedef enum logic [2:0] {StIdle, StIfRd, StLsRd, StLsWr, StDone} state_e;

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [2:0]         len_q, len_d;
  logic [ADR_W-1:0]   adr_q, adr_d;
  logic [DAT_W-1:0]   dat_q, dat_d;
  logic               grant_lsb_q, grant_lsb_d;
  logic               last_lsb_q, last_lsb_d;
  logic               restart_q, restart_d;
  logic [ADR_W-1:0]   mem_a_q, mem_a_d;
  logic [7:0]         mem_dout_q, mem_dout_d;
  logic               mem_wr_q, mem_wr_d;
  logic               if_done_q, if_done_d;
  logic               lsb_done_q, lsb_done_d;
  logic [DAT_W-1:0]   if_dat_q, if_dat_d;
  logic [DAT_W-1:0]   lsb_dat_q, lsb_dat_d;

  logic [2:0]         lsb_len_n;
  logic [2:0]         nxt_cnt;
  logic [1:0]         cap_idx;
  logic [DAT_W-1:0]   dat_cap;
  logic [ADR_W-1:0]   wr_adr;
  logic [7:0]         wr_byte;
  logic               gnt_if, gnt_lsb;

  assign lsb_len_n = (lsb_len_i == 3'd1) ? 3'd1 : (lsb_len_i == 3'd2) ? 3'd2 : 3'd4;
  assign nxt_cnt   = cnt_q + 3'd1;
  assign cap_idx   = cnt_q[1:0] - 2'd1;
  assign wr_adr    = adr_q + ADR_W'(cnt_q);
  assign wr_byte   = dat_q[{cnt_q[1:0], 3'b000} +: 8];

  // Read data arriving now belongs to the byte whose address went out two edges ago.
  always_comb begin
    dat_cap = dat_q;
    for (int b = 0; b < NB; b++) begin
      if (cap_idx == b[1:0]) dat_cap[8*b +: 8] = mem_din;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    grant_lsb_d = grant_lsb_q;
    last_lsb_d  = last_lsb_q;
    restart_d   = restart_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = mem_wr_q;
    if_done_d   = if_done_q;
    lsb_done_d  = lsb_done_q;
    if_dat_d    = if_dat_q;
    lsb_dat_d   = lsb_dat_q;
    gnt_lsb     = 1'b0;
    gnt_if      = 1'b0;

    if (en) begin
      if_done_d  = 1'b0;
      lsb_done_d = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!br_flag_i) begin
            gnt_lsb = lsb_en_i && (!if_en_i || !last_lsb_q);
            gnt_if  = if_en_i && !gnt_lsb;
          end
          if (gnt_if || gnt_lsb) begin
            last_lsb_d  = gnt_lsb;
            grant_lsb_d = gnt_lsb;
            cnt_d       = 3'd0;
            restart_d   = 1'b0;
            if (gnt_if) begin
              adr_d   = if_adr_i;
              len_d   = 3'd4;
              dat_d   = '0;
              mem_a_d = if_adr_i;
              state_d = StIfRd;
            end else begin
              adr_d   = lsb_adr_i;
              len_d   = lsb_len_n;
              mem_a_d = lsb_adr_i;
              if (lsb_rwen_i) begin
                dat_d   = lsb_dat_i;
                state_d = StLsWr;
                if (!(lsb_adr_i[17:16] == 2'b11 && io_buffer_full)) begin
                  mem_wr_d   = 1'b1;
                  mem_dout_d = lsb_dat_i[7:0];
                  cnt_d      = 3'd1;
                end
              end else begin
                dat_d   = '0;
                state_d = StLsRd;
              end
            end
          end
        end
        StIfRd, StLsRd: begin
          if (br_flag_i) begin
            state_d   = StIdle;
            mem_a_d   = '0;
            restart_d = 1'b0;
          end else if (restart_q) begin
            mem_a_d   = adr_q;
            cnt_d     = 3'd0;
            dat_d     = '0;
            restart_d = 1'b0;
          end else begin
            if (nxt_cnt < len_q) mem_a_d = adr_q + ADR_W'(nxt_cnt);
            if (cnt_q != 3'd0) dat_d = dat_cap;
            cnt_d = nxt_cnt;
            if (cnt_q == len_q) begin
              state_d = StDone;
              if (grant_lsb_q) begin
                lsb_done_d = 1'b1;
                lsb_dat_d  = dat_cap;
              end else begin
                if_done_d = 1'b1;
                if_dat_d  = dat_cap;
              end
            end
          end
        end
        StLsWr: begin
          if (cnt_q == len_q) begin
            state_d    = StDone;
            mem_wr_d   = 1'b0;
            lsb_done_d = 1'b1;
          end else if (wr_adr[17:16] == 2'b11 && io_buffer_full) begin
            mem_wr_d = 1'b0;
          end else begin
            mem_a_d    = wr_adr;
            mem_dout_d = wr_byte;
            mem_wr_d   = 1'b1;
            cnt_d      = nxt_cnt;
          end
        end
        StDone: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end else if (state_q == StIfRd || state_q == StLsRd) begin
      // The RAM pipeline keeps running while frozen, so in-flight bytes are stale on resume.
      restart_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      len_q       <= 3'd0;
      adr_q       <= '0;
      dat_q       <= '0;
      grant_lsb_q <= 1'b0;
      last_lsb_q  <= 1'b0;
      restart_q   <= 1'b0;
      mem_a_q     <= '0;
      mem_dout_q  <= 8'd0;
      mem_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
      if_dat_q    <= '0;
      lsb_dat_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      grant_lsb_q <= grant_lsb_d;
      last_lsb_q  <= last_lsb_d;
      restart_q   <= restart_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      if_done_q   <= if_done_d;
      lsb_done_q  <= lsb_done_d;
      if_dat_q    <= if_dat_d;
      lsb_dat_q   <= lsb_dat_d;
    end
  end

  assign mem_a      = mem_a_q;
  assign mem_dout   = mem_dout_q;
  assign mem_wr     = mem_wr_q & en;
  assign if_done_o  = if_done_q & en;
  assign lsb_done_o = lsb_done_q & en;
  assign if_dat_o   = if_dat_q;
  assign lsb_dat_o  = lsb_dat_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a table of single transactions plus hand-written
// sequences for arbitration, IO hold, flush, stale requests, freeze and reset.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        if_en_i, lsb_en_i, lsb_rwen_i, br_flag_i;
  logic [31:0] if_adr_i, lsb_adr_i, lsb_dat_i;
  logic [2:0]  lsb_len_i;
  logic        if_done_o, lsb_done_o;
  logic [31:0] if_dat_o, lsb_dat_o;

  int n_pass = 0;
  int n_total = 0;

  mem_ctrl #(.ADR_W(32), .DAT_W(32)) dut (
    .clk(clk), .rst(rst), .en(en), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
    .mem_wr(mem_wr), .io_buffer_full(io_buffer_full), .if_en_i(if_en_i), .if_adr_i(if_adr_i),
    .if_done_o(if_done_o), .if_dat_o(if_dat_o), .lsb_en_i(lsb_en_i), .lsb_rwen_i(lsb_rwen_i),
    .lsb_len_i(lsb_len_i), .lsb_adr_i(lsb_adr_i), .lsb_dat_i(lsb_dat_i),
    .lsb_done_o(lsb_done_o), .lsb_dat_o(lsb_dat_o), .br_flag_i(br_flag_i)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    case (a)
      32'h1000: rd_byte = 8'h13;
      32'h1001: rd_byte = 8'h00;
      32'h1002: rd_byte = 8'h00;
      32'h1003: rd_byte = 8'h93;
      32'h0020: rd_byte = 8'hFF;
      32'h0021: rd_byte = 8'h80;
      default:  rd_byte = a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // Synchronous RAM model plus a log of every write strobe it sees.
  logic [31:0] wr_adr_log [0:127];
  logic [7:0]  wr_dat_log [0:127];
  int          wr_n = 0;
  always @(posedge clk) begin
    mem_din <= rd_byte(mem_a);
    if (mem_wr) begin
      wr_adr_log[wr_n] <= mem_a;
      wr_dat_log[wr_n] <= mem_dout;
      wr_n <= wr_n + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic chk_writes(input string name, input int base, input int n,
                            input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] d;
    d = dat;
    chk({name, " count"}, 64'(wr_n - base), 64'(n));
    for (int i = 0; i < n; i++) begin
      chk({name, " adr"}, 64'(wr_adr_log[base+i]), 64'(adr + 32'(i)));
      chk({name, " byte"}, 64'(wr_dat_log[base+i]), 64'((d >> (8*i)) & 32'hFF));
    end
  endtask

  typedef struct {
    bit          is_lsb;
    bit          rwen;
    logic [2:0]  len;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] exp_dat;
    int          exp_lat;
    int          nbytes;
  } vec_t;

  task automatic run_req(input vec_t v, output int lat, output logic [31:0] dat,
                         output int other);
    @(negedge clk);
    if (v.is_lsb) begin
      lsb_en_i = 1'b1; lsb_rwen_i = v.rwen; lsb_len_i = v.len;
      lsb_adr_i = v.adr; lsb_dat_i = v.wdat;
    end else begin
      if_en_i = 1'b1; if_adr_i = v.adr;
    end
    lat = -1; other = 0; dat = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (v.is_lsb ? if_done_o : lsb_done_o) other++;
      if (v.is_lsb ? lsb_done_o : if_done_o) begin
        lat = k;
        dat = v.is_lsb ? lsb_dat_o : if_dat_o;
        break;
      end
    end
    if_en_i = 1'b0; lsb_en_i = 1'b0;
  endtask

  vec_t vecs [8];

  initial begin
    int lat, other, base, cnt, dups;
    logic [31:0] dat;
    logic [3:0]  order;

    vecs[0] = '{0, 0, 3'd4, 32'h0000_1000, 32'h0, 32'h9300_0013, 6, 0};
    vecs[1] = '{1, 0, 3'd2, 32'h0000_0020, 32'h0, 32'h0000_80FF, 4, 0};
    vecs[2] = '{1, 0, 3'd1, 32'h0000_0021, 32'h0, 32'h0000_0080, 3, 0};
    vecs[3] = '{1, 0, 3'd4, 32'h0000_0044, 32'h0, 32'h1D1C_1F1E, 6, 0};
    vecs[4] = '{1, 0, 3'd7, 32'h0000_0100, 32'h0, 32'h5958_5B5A, 6, 0};
    vecs[5] = '{1, 1, 3'd2, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0, 3, 2};
    vecs[6] = '{1, 1, 3'd4, 32'h0000_0300, 32'h1122_3344, 32'h0, 5, 4};
    vecs[7] = '{0, 0, 3'd4, 32'hFFFF_FFFE, 32'h0, 32'h5B5A_A5A4, 6, 0};

    rst = 1'b1; en = 1'b1; io_buffer_full = 1'b0; br_flag_i = 1'b0;
    if_en_i = 1'b0; if_adr_i = '0; lsb_en_i = 1'b0; lsb_rwen_i = 1'b0;
    lsb_len_i = '0; lsb_adr_i = '0; lsb_dat_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset outputs", {mem_a, mem_dout, mem_wr, if_done_o, lsb_done_o, 5'b0}, 64'h0);
    chk("reset data", {if_dat_o, lsb_dat_o}, 64'h0);

    // Tie from reset: LSB first, then alternate while both stay requested.
    if_en_i = 1'b1; if_adr_i = 32'h1000;
    lsb_en_i = 1'b1; lsb_rwen_i = 1'b0; lsb_len_i = 3'd1; lsb_adr_i = 32'h21;
    cnt = 0; order = '0; lat = -1;
    for (int k = 1; k <= 80 && cnt < 4; k++) begin
      @(negedge clk);
      if (if_done_o && lsb_done_o) chk("tie both done", 1, 0);
      if (lsb_done_o || if_done_o) begin
        order = {order[2:0], lsb_done_o};
        if (cnt == 0) lat = k;
        if (lsb_done_o) chk("tie lsb data", lsb_dat_o, 32'h80);
        else chk("tie if data", if_dat_o, 32'h9300_0013);
        cnt++;
      end
    end
    if_en_i = 1'b0; lsb_en_i = 1'b0;
    chk("tie done count", cnt, 4);
    chk("tie order", order, 4'b1010);
    chk("tie first latency", lat, 3);

    foreach (vecs[i]) begin
      base = wr_n;
      run_req(vecs[i], lat, dat, other);
      chk($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d other done", i), other, 0);
      if (vecs[i].rwen) begin
        @(negedge clk);
        chk_writes($sformatf("vec%0d write", i), base, vecs[i].nbytes, vecs[i].adr,
                   vecs[i].wdat);
      end else begin
        chk($sformatf("vec%0d data", i), dat, vecs[i].exp_dat);
        chk($sformatf("vec%0d no writes", i), wr_n - base, 0);
      end
    end

    // IO store held off for three cycles by io_buffer_full.
    @(negedge clk);
    base = wr_n;
    lsb_en_i = 1'b1; lsb_rwen_i = 1'b1; lsb_len_i = 3'd1;
    lsb_adr_i = 32'h0003_0000; lsb_dat_i = 32'h0000_00A5; io_buffer_full = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("io hold mem_wr", mem_wr, 0);
      if (k == 3) io_buffer_full = 1'b0;
    end
    @(negedge clk);
    chk("io issue mem_wr", mem_wr, 1);
    chk("io issue byte", mem_dout, 8'hA5);
    chk("io issue adr", mem_a, 32'h0003_0000);
    @(negedge clk);
    chk("io done", lsb_done_o, 1);
    chk("io done mem_wr", mem_wr, 0);
    lsb_en_i = 1'b0;
    chk("io write count", wr_n - base, 1);

    // Flush during byte 2 of a fetch.
    @(negedge clk);
    if_en_i = 1'b1; if_adr_i = 32'h1000;
    repeat (3) @(negedge clk);
    chk("flush byte2 adr", mem_a, 32'h1002);
    br_flag_i = 1'b1; if_en_i = 1'b0;
    @(negedge clk);
    br_flag_i = 1'b0;
    chk("flush mem_a", mem_a, 0);
    chk("flush no done", if_done_o, 0);
    run_req(vecs[2], lat, dat, other);
    chk("after flush latency", lat, 3);
    chk("after flush data", dat, 32'h80);
    chk("after flush no if_done", other, 0);

    // Flush is ignored by a word store.
    @(negedge clk);
    base = wr_n;
    lsb_en_i = 1'b1; lsb_rwen_i = 1'b1; lsb_len_i = 3'd4;
    lsb_adr_i = 32'h400; lsb_dat_i = 32'hCAFE_F00D;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      br_flag_i = 1'b1;
      if (lsb_done_o) begin lat = k; break; end
    end
    br_flag_i = 1'b0; lsb_en_i = 1'b0;
    chk("flush sw latency", lat, 5);
    chk_writes("flush sw", base, 4, 32'h400, 32'hCAFE_F00D);

    // Fetch request held into the idle cycle after done must not restart.
    @(negedge clk);
    if_en_i = 1'b1; if_adr_i = 32'h1000;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (if_done_o) begin lat = k; break; end
    end
    chk("stale latency", lat, 6);
    @(negedge clk);
    if_en_i = 1'b0;
    dups = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (if_done_o || mem_a != 32'h1003) dups++;
    end
    chk("stale no reaccept", dups, 0);

    // Freeze during a write: strobe gated, same byte resumes.
    @(negedge clk);
    base = wr_n;
    lsb_en_i = 1'b1; lsb_rwen_i = 1'b1; lsb_len_i = 3'd2;
    lsb_adr_i = 32'h600; lsb_dat_i = 32'h0000_7788;
    @(negedge clk);
    chk("freeze pre mem_wr", mem_wr, 1);
    en = 1'b0;
    #1 chk("freeze gated mem_wr", mem_wr, 0);
    @(negedge clk);
    chk("freeze held adr", mem_a, 32'h600);
    en = 1'b1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (lsb_done_o) begin lat = k; break; end
    end
    lsb_en_i = 1'b0;
    chk("freeze resume latency", lat, 2);
    chk_writes("freeze write", base, 2, 32'h600, 32'h0000_7788);

    // Reset in the middle of a word store.
    @(negedge clk);
    lsb_en_i = 1'b1; lsb_rwen_i = 1'b1; lsb_len_i = 3'd4;
    lsb_adr_i = 32'h500; lsb_dat_i = 32'h0102_0304;
    repeat (2) @(negedge clk);
    chk("rst pre mem_wr", mem_wr, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst outputs", {mem_a, mem_dout, mem_wr, if_done_o, lsb_done_o, 5'b0}, 64'h0);
    chk("rst data", {if_dat_o, lsb_dat_o}, 64'h0);
    rst = 1'b0; lsb_en_i = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
